// File: rtl/sys_psum_drain.sv
// -----------------------------------------------------------------------------
// sys_psum_drain
//
// Collects the bottom-row partial sums from the systolic array. The array
// emits its columns one cycle apart, so this block first removes that skew to
// get one aligned vector per row. It then accumulates each row across the
// configured number of K-tile passes in an internal row buffer. When the last
// pass is complete, it drains the finished rows through a valid/ready stream.
//
// Optional build macro:
//   SYS_PSUM_DRAIN_SAT_EN - when defined, accumulation saturates per lane to
//                           the signed ACC_WIDTH range. The overwrite pass is
//                           unaffected. When undefined, accumulation wraps.
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-high
//   cfg_start   pulse, accepted only in IDLE; latches cfg_rows / cfg_passes
//   cfg_rows    rows per pass, 1..ACC_DEPTH
//   cfg_passes  K-tile passes, 1..255
//   en_in       per-column psum valid from the array bottom row (skewed)
//   psum_in     per-column psum; lane c is at [c*PSUM_WIDTH +: PSUM_WIDTH]
//   out_valid   drained row valid
//   out_ready   consumer ready
//   out_data    accumulated row; lane c is at [c*ACC_WIDTH +: ACC_WIDTH]
//   out_last    high with the final drained row
//   busy        state != IDLE
//   done        one-cycle pulse after the last row handshake
//   err         sticky skew-mismatch / overrun / bad-config flag; cleared by rst
// -----------------------------------------------------------------------------
module sys_psum_drain #(
  parameter int SYS_COL    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int ACC_DEPTH  = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_start,
  input  logic [$clog2(ACC_DEPTH+1)-1:0]         cfg_rows,
  input  logic [7:0]                             cfg_passes,
  input  logic [SYS_COL-1:0]                     en_in,
  input  logic [SYS_COL*2*DATA_WIDTH-1:0]        psum_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [SYS_COL*ACC_WIDTH-1:0]           out_data,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  localparam int PSUM_WIDTH = 2 * DATA_WIDTH;
  localparam int CNT_W      = $clog2(ACC_DEPTH + 1);
  localparam int IDX_W      = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_e;

  typedef logic [SYS_COL-1:0][ACC_WIDTH-1:0] row_t;

  // ---------------------------------------------------------------------------
  // Deskew: column c is delayed SYS_COL-c stages, so all columns of one row
  // line up SYS_COL cycles after its column 0 entered.
  // ---------------------------------------------------------------------------
  logic [SYS_COL-1:0][PSUM_WIDTH-1:0] psum_lanes;
  logic [SYS_COL-1:0][PSUM_WIDTH-1:0] al_psum;
  logic [SYS_COL-1:0]                 al_en;

  assign psum_lanes = psum_in;

  for (genvar c = 0; c < SYS_COL; c++) begin : g_col
    localparam int D = SYS_COL - c;
    logic [D-1:0]                 en_sr_q;
    logic [D-1:0][PSUM_WIDTH-1:0] dat_sr_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        en_sr_q <= '0;
      end else begin
        en_sr_q[0] <= en_in[c];
        for (int s = 1; s < D; s++) en_sr_q[s] <= en_sr_q[s-1];
      end
    end

    // Data stages need no reset: they are qualified by the en stages.
    always_ff @(posedge clk) begin
      dat_sr_q[0] <= psum_lanes[c];
      for (int s = 1; s < D; s++) dat_sr_q[s] <= dat_sr_q[s-1];
    end

    assign al_en[c]   = en_sr_q[D-1];
    assign al_psum[c] = dat_sr_q[D-1];
  end

  logic vec_valid;
  logic vec_partial;
  assign vec_valid   = &al_en;
  assign vec_partial = (|al_en) && !vec_valid;

  // ---------------------------------------------------------------------------
  // Per-lane accumulate: the first pass overwrites, later passes add.
  // ---------------------------------------------------------------------------
  function automatic logic [ACC_WIDTH-1:0] lane_acc(input logic [ACC_WIDTH-1:0]  old_v,
                                                    input logic [PSUM_WIDTH-1:0] p,
                                                    input logic                  first);
    logic [ACC_WIDTH-1:0] ext;
    ext                   = {ACC_WIDTH{p[PSUM_WIDTH-1]}};
    ext[PSUM_WIDTH-1:0]   = p;
    if (first) return ext;
`ifdef SYS_PSUM_DRAIN_SAT_EN
    begin
      logic [ACC_WIDTH:0] sum;
      sum = {old_v[ACC_WIDTH-1], old_v} + {ext[ACC_WIDTH-1], ext};
      // The two top bits differ only when the signed add overflowed.
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
        return sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      return sum[ACC_WIDTH-1:0];
    end
`else
    return old_v + ext;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] rows_q, rows_d;
  logic [7:0]       passes_q, passes_d;
  logic [CNT_W-1:0] row_ptr_q, row_ptr_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  row_t             out_data_q, out_data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // NOTE: the row buffer has no reset; its contents are always overwritten by
  // the first pass before they are read, and a memory reset costs a full
  // clear that synthesis cannot map onto RAM.
  row_t row_buf_q [ACC_DEPTH];
  logic buf_we;
  row_t buf_wdata;

  logic [CNT_W-1:0] last_row;
  logic [CNT_W-1:0] rd_next;
  assign last_row = rows_q - CNT_W'(1);
  assign rd_next  = rd_ptr_q + CNT_W'(1);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d     = state_q;
    rows_d      = rows_q;
    passes_d    = passes_q;
    row_ptr_d   = row_ptr_q;
    pass_cnt_d  = pass_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    err_d       = err_q | vec_partial;
    buf_we      = 1'b0;

    for (int c = 0; c < SYS_COL; c++)
      buf_wdata[c] = lane_acc(row_buf_q[row_ptr_q[IDX_W-1:0]][c], al_psum[c],
                              pass_cnt_q == 8'd0);

    unique case (state_q)
      S_IDLE: begin
        if (vec_valid) err_d = 1'b1;
        if (cfg_start) begin
          if (cfg_rows == '0 || cfg_passes == 8'd0) begin
            err_d = 1'b1;
          end else begin
            rows_d     = cfg_rows;
            passes_d   = cfg_passes;
            row_ptr_d  = '0;
            pass_cnt_d = 8'd0;
            state_d    = S_FILL;
          end
        end
      end

      S_FILL: begin
        if (vec_valid) begin
          buf_we = 1'b1;
          if (row_ptr_q == last_row) begin
            row_ptr_d  = '0;
            pass_cnt_d = pass_cnt_q + 8'd1;
            if (pass_cnt_q == passes_q - 8'd1) begin
              state_d  = S_DRAIN;
              rd_ptr_d = '0;
            end
          end else begin
            row_ptr_d = row_ptr_q + CNT_W'(1);
          end
        end
      end

      S_DRAIN: begin
        if (vec_valid) err_d = 1'b1;
        if (!out_valid_q) begin
          // First DRAIN cycle: fetch row 0 into the output register.
          out_valid_d = 1'b1;
          out_data_d  = row_buf_q[rd_ptr_q[IDX_W-1:0]];
          out_last_d  = (rd_ptr_q == last_row);
        end else if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            rd_ptr_d   = rd_next;
            out_data_d = row_buf_q[rd_next[IDX_W-1:0]];
            out_last_d = (rd_next == last_row);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      passes_q    <= 8'd0;
      row_ptr_q   <= '0;
      pass_cnt_q  <= 8'd0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      passes_q    <= passes_d;
      row_ptr_q   <= row_ptr_d;
      pass_cnt_q  <= pass_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) row_buf_q[row_ptr_q[IDX_W-1:0]] <= buf_wdata;
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/sys_psum_drain.md
Name: sys_psum_drain

Overview:
Downstream collector for the bottom row of the systolic array. The array emits column psums staggered by one cycle per column, and this block removes that skew so each row arrives as one aligned vector. It accumulates each aligned vector across multiple K-tile passes into an internal row buffer. It then drains the finished rows through a valid/ready stream to the output/activation stage.

Parameters:
SYS_COL, 16, number of array columns; psum lanes per vector
DATA_WIDTH, 16, array operand width
PSUM_WIDTH, 2*DATA_WIDTH (localparam), array psum width
ACC_WIDTH, 40, accumulator width per lane; must be >= PSUM_WIDTH
ACC_DEPTH, 32, max output rows buffered

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_start  in  1  pulse; latches cfg_rows/cfg_passes; accepted only in IDLE
cfg_rows  in  $clog2(ACC_DEPTH+1)  rows per pass, 1..ACC_DEPTH
cfg_passes  in  8  K-tile passes, 1..255
en_in  in  SYS_COL  per-column psum valid from the array bottom row (skewed)
psum_in  in  PSUM_WIDTH x SYS_COL  per-column psum (skewed)
out_valid  out  1  drained row valid
out_ready  in  1  consumer ready
out_data  out  ACC_WIDTH x SYS_COL  accumulated row
out_last  out  1  high with the final drained row
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last row handshake
err  out  1  sticky: skew mismatch or overrun; cleared only by rst

Behaviour:
- Reset: state=IDLE; all outputs 0; counters 0; deskew valid pipeline cleared. Buffer contents are don't-care.
- Deskew:
  - Column c passes through 1 + (SYS_COL-1-c) register stages (data and en).
  - A row whose column 0 is valid at cycle t appears aligned at cycle t+SYS_COL.
  - The aligned vector is valid when all delayed en bits are 1.
  - If some delayed en bits are 1 and others are 0, set err and drop the vector.
- States: IDLE, FILL, DRAIN.
- IDLE:
  - cfg_start → FILL.
  - Latch cfg values; row_ptr=0, pass_cnt=0.
  - cfg_rows=0 or cfg_passes=0 → set err, stay IDLE.
- FILL, per aligned valid vector:
  - Sign-extend each lane to ACC_WIDTH.
  - pass_cnt==0 → buf[row_ptr] = psum (overwrite).
  - Otherwise → buf[row_ptr] += psum, two's-complement wrap modulo 2^ACC_WIDTH.
  - Buffer write completes the same cycle as aligned valid.
  - row_ptr increments. At cfg_rows-1 it wraps to 0 and pass_cnt increments.
  - On the write of the last row of the last pass → DRAIN next cycle, rd_ptr=0.
- DRAIN:
  - out_valid=1 and out_data=buf[rd_ptr] (registered read; data is stable while valid && !ready).
  - out_last = (rd_ptr==cfg_rows-1).
  - Handshake (valid && ready) → rd_ptr++.
  - Handshake on the last row → IDLE, with done=1 for one cycle in the first IDLE cycle.
  - First out_valid appears the cycle after entering DRAIN.
- Overrun: an aligned valid vector in IDLE or DRAIN is dropped and sets err.
  - The deskew pipeline keeps running in all states.
- Simultaneous events: cfg_start during FILL or DRAIN is ignored; it does not set err.
- Reset asserted mid-FILL or mid-DRAIN: next cycle IDLE, outputs 0, in-flight deskew data discarded.
- Throughput: one aligned vector per cycle in FILL, one row per cycle in DRAIN when out_ready=1.

Optional Feature:
SYS_PSUM_DRAIN_SAT_EN
- Defined: accumulation saturates per lane to the signed ACC_WIDTH range, +2^(ACC_WIDTH-1)-1 and -2^(ACC_WIDTH-1). The overwrite pass is unaffected.
- Undefined: accumulation wraps as specified above. Saturation logic is absent.

Test Plan:
Use SYS_COL=4, ACC_WIDTH=40.
1. Single pass. cfg_rows=2, passes=1. Feed row0 psum {1,2,3,4} and row1 {5,6,7,8}, skewed one cycle per column. → out rows {1,2,3,4} then {5,6,7,8}; out_last on the 2nd row; done pulse; err=0.
2. Accumulate. cfg_rows=1, passes=3. Feed {10,-3,0,7} each pass. → single row {30,-9,0,21}; first out_valid 1 cycle after the last write.
3. Backpressure. Same as test 1 with out_ready low for 3 cycles on row0. → out_data holds {1,2,3,4} stable; no row skipped or duplicated.
4. Skew error and overrun:
   - Drop en_in[2] for one row. → err=1; that vector is not written; row_ptr unchanged.
   - Separately, a valid row in IDLE. → err=1.
5. Reset mid-FILL. Assert rst after 1 of 2 rows, then restart with cfg_rows=1, passes=1, {9,9,9,9}. → output {9,9,9,9} only; no stale data.
6. Wrap/saturate. passes=2, lane0 = 0x7FFFFFFF twice with ACC_WIDTH=32 override.
   - Without macro: lane0 wraps to 0xFFFFFFFE (-2).
   - With SYS_PSUM_DRAIN_SAT_EN: lane0 = 0x7FFFFFFF.
